wrapper_lfsr_tpg: RTL
=====================

Name: wrapper_lfsr_tpg

Overview:
- Memory-mapped LFSR test-pattern generator; the stimulus source paired with the MISR response compactor in the BIST path.
- Software programs seed, feedback coefficients and pattern count through the same register-bus interface as the MISR wrapper, then starts a run.
- The block emits pseudorandom patterns to the unit under test over a valid/ready stream.

Parameters:
- NBIT_DATA, 64, pattern and LFSR width.
- NBIT_ADDR, 64, register-bus address width.
- NBIT_REGS, 64, software register width; register stride = NBIT_REGS/8 bytes.
- START_ADDR, 2**25 + 64, base address of the register window.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- re_i  in  1  register read request.
- we_i  in  1  register write request; we_i takes priority over re_i.
- addr_i  in  NBIT_ADDR  register address.
- data_csr_i  in  NBIT_REGS  register write data.
- data_sw_o  out  NBIT_REGS  register read data, combinational.
- pattern_o  out  NBIT_DATA  current pattern.
- pattern_valid_o  out  1  pattern_o valid.
- pattern_ready_i  in  1  consumer accepts the pattern.
- done_o  out  1  run complete.

Behaviour:
- Registers, at START_ADDR + k*stride:
  - k=0 CONTROL (rw): bit0 START and bit1 ABORT are write-one pulses, self-clearing; they read as 0.
  - k=1 SEED (rw).
  - k=2 COEFF (rw).
  - k=3 COUNT (rw).
  - k=4 STATUS (ro): bit0 busy, bit1 done.
  - k=5 EMITTED (ro): number of accepted patterns.
- Reads of unmapped addresses return 0. Writes to read-only registers are ignored.
- Reset: all registers 0, state IDLE, pattern_o=0, pattern_valid_o=0, done_o=0, data_sw_o=0.
- FSM states:
  - IDLE: START moves to LOAD.
  - LOAD (1 cycle): lfsr<=SEED, or 1 if SEED==0; EMITTED<=0. If COUNT==0, go to DONE; else go to RUN.
  - RUN: pattern_valid_o=1 and pattern_o=lfsr.
    - On valid&&ready: EMITTED++. If EMITTED+1==COUNT, go to DONE; else lfsr<=next(lfsr).
    - Without ready: pattern_o is held stable.
  - DONE: done_o=1, valid=0. START moves to LOAD.
- LFSR step: next = {lfsr[N-2:0], ^(lfsr & COEFF)}, Fibonacci form, feedback parity enters the LSB.
- Latency: START write at cycle t gives valid=1 at t+2.
- ABORT in any state: next state IDLE, valid=0, done=0. ABORT and START written together: ABORT wins.
- START in LOAD or RUN is ignored.
- Writes to SEED, COEFF and COUNT while busy (LOAD or RUN) are ignored.
- busy = state is LOAD or RUN.
- EMITTED saturates at all-ones.

Optional Feature:
- Macro TPG_CONTINUOUS_EN.
- Defined: CONTROL bit2 CONT (rw, persistent). When CONT=1, COUNT is ignored and the run continues until ABORT; the COUNT==0 shortcut to DONE is bypassed.
- Undefined: bit2 reads 0, writes to it have no effect, and the run always uses COUNT.

Decomposition:
- Package tpg_pkg holds:
  - register offset indices k=0..5;
  - CONTROL bit indices START=0, ABORT=1, CONT=2;
  - STATUS bit indices BUSY=0, DONE=1;
  - state enum {IDLE, LOAD, RUN, DONE}.
- Sub-module generic_lfsr (N): lfsr register with load/seed/step/coeff inputs and q output. It is the mirror of generic_MISR without the data input.

Test Plan (NBIT_DATA=NBIT_REGS=8, register stride 1 byte):
- Sequence: SEED=0x01, COEFF=0xB8, COUNT=5, START, ready held 1 -> patterns 0x01,0x02,0x04,0x08,0x11; then done_o=1, STATUS=0x02, EMITTED=5.
- Stall: same setup with ready=0 for 3 cycles on the 3rd pattern -> 0x04 held stable with valid=1; EMITTED unchanged until ready.
- Zero-count: COUNT=0, START -> no valid pulse; done_o=1 two cycles after the write.
- Zero seed: SEED=0, COUNT=2 -> patterns 0x01,0x02.
- Abort: ABORT during RUN after 2 patterns -> valid=0 next cycle, STATUS=0x00, EMITTED=2.
  - START+ABORT written together (CONTROL=0x03) -> stays IDLE.
  - SEED write while busy -> reads back the old value.
- Reset: rst_ni low mid-RUN -> all outputs 0 immediately, registers 0; TPG_CONTINUOUS_EN run produces more than COUNT patterns until ABORT.

Source files
------------

// File: rtl/wrapper_lfsr_tpg_pkg.sv
// Shared definitions for the LFSR test-pattern generator: register map, bit fields, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tpg_pkg;

   // Register indices; the byte address is START_ADDR + k * (NBIT_REGS/8)
   localparam logic [2:0] REG_CONTROL = 3'd0;
   localparam logic [2:0] REG_SEED    = 3'd1;
   localparam logic [2:0] REG_COEFF   = 3'd2;
   localparam logic [2:0] REG_COUNT   = 3'd3;
   localparam logic [2:0] REG_STATUS  = 3'd4;
   localparam logic [2:0] REG_EMITTED = 3'd5;
   localparam int         REG_NUM     = 6;

   // CONTROL bits: START/ABORT are write-one pulses, CONT is a stored mode bit
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_CONT  = 2;

   // STATUS bits
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

endpackage

// File: rtl/wrapper_lfsr_tpg_if.sv
// Register-bus interface shared with the MISR wrapper; data_sw_o is driven combinationally by the slave.
// Latency: reads combinational, writes take effect on the next clock edge.
// Backpressure: none; the bus is always accepted.
interface wrapper_lfsr_tpg_if #(
   parameter int NBIT_ADDR = 64,
   parameter int NBIT_REGS = 64
);
   logic                 re_i;
   logic                 we_i;
   logic [NBIT_ADDR-1:0] addr_i;
   logic [NBIT_REGS-1:0] data_csr_i;
   logic [NBIT_REGS-1:0] data_sw_o;

   modport master (output re_i, we_i, addr_i, data_csr_i, input data_sw_o);
   modport slave  (input re_i, we_i, addr_i, data_csr_i, output data_sw_o);
endinterface

// File: rtl/wrapper_lfsr_tpg_lfsr.sv
// Fibonacci LFSR register: parallel load (zero seed forced to 1) or one step per cycle.
// Latency: load/step visible on q_o one cycle later.
// Backpressure: holds its value whenever neither load nor step is asserted.
module generic_lfsr #(
   parameter int N = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [N-1:0] seed_i,
   input  logic [N-1:0] coeff_i,
   output logic [N-1:0] q_o
);
   logic [N-1:0] lfsr_q, lfsr_d;

   // Next value: load wins over step; an all-zero seed would lock the LFSR, so substitute 1
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = (seed_i == '0) ? N'(1) : seed_i;
      end else if (step_i) begin
         lfsr_d = {lfsr_q[N-2:0], ^(lfsr_q & coeff_i)};
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= '0;
      else         lfsr_q <= lfsr_d;
   end

   assign q_o = lfsr_q;
endmodule

// File: rtl/wrapper_lfsr_tpg.sv
// Memory-mapped LFSR pattern source; optional continuous mode under TPG_CONTINUOUS_EN.
// Latency: START write at cycle t gives pattern_valid_o at t+2; register reads are combinational.
// Backpressure: pattern_o held stable while pattern_valid_o && !pattern_ready_i.
module wrapper_lfsr_tpg
   import tpg_pkg::*;
#(
   parameter int              NBIT_DATA  = 64,
   parameter int              NBIT_ADDR  = 64,
   parameter int              NBIT_REGS  = 64,
   parameter longint unsigned START_ADDR = 64'd33554496
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   wrapper_lfsr_tpg_if.slave    bus,
   output logic [NBIT_DATA-1:0] pattern_o,
   output logic                 pattern_valid_o,
   input  logic                 pattern_ready_i,
   output logic                 done_o
);
   localparam int STRIDE = NBIT_REGS / 8;

   state_e               state_q, state_d;
   logic [NBIT_REGS-1:0] seed_q, coeff_q, count_q, emitted_q, emitted_d;
   logic [NBIT_DATA-1:0] lfsr;
   logic                 lfsr_load, lfsr_step;
   logic [NBIT_ADDR-1:0] off;
   logic [2:0]           idx;
   logic                 hit, wr_en, rd_en, start, abort, busy, cont;

   // Address decode: aligned offsets inside the six-register window only
   assign off   = bus.addr_i - NBIT_ADDR'(START_ADDR);
   assign hit   = (off % NBIT_ADDR'(STRIDE) == '0) &&
                  (off / NBIT_ADDR'(STRIDE) < NBIT_ADDR'(REG_NUM));
   assign idx   = 3'(off / NBIT_ADDR'(STRIDE));
   assign wr_en = bus.we_i && hit;
   assign rd_en = bus.re_i && !bus.we_i && hit;
   assign start = wr_en && (idx == REG_CONTROL) && bus.data_csr_i[CTRL_START];
   assign abort = wr_en && (idx == REG_CONTROL) && bus.data_csr_i[CTRL_ABORT];
   assign busy  = (state_q == LOAD) || (state_q == RUN);

`ifdef TPG_CONTINUOUS_EN
   logic cont_q;

   // CONT is a persistent mode bit, writable in any state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                            cont_q <= 1'b0;
      else if (wr_en && idx == REG_CONTROL)   cont_q <= bus.data_csr_i[CTRL_CONT];
   end
   assign cont = cont_q;
`else
   assign cont = 1'b0;
`endif

   // Configuration registers; frozen while a run is loading or streaming
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seed_q  <= '0;
         coeff_q <= '0;
         count_q <= '0;
      end else if (wr_en && !busy) begin
         case (idx)
            REG_SEED:  seed_q  <= bus.data_csr_i;
            REG_COEFF: coeff_q <= bus.data_csr_i;
            REG_COUNT: count_q <= bus.data_csr_i;
            default: ;
         endcase
      end
   end

   // FSM next state, LFSR controls and EMITTED update; ABORT overrides everything
   always_comb begin
      state_d   = state_q;
      emitted_d = emitted_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            lfsr_load = 1'b1;
            emitted_d = '0;
            state_d   = (count_q == '0 && !cont) ? DONE : RUN;
         end
         RUN: if (pattern_ready_i) begin
            if (emitted_q != '1) emitted_d = emitted_q + NBIT_REGS'(1);
            if (!cont && (emitted_q + NBIT_REGS'(1) == count_q)) state_d = DONE;
            else                                                 lfsr_step = 1'b1;
         end
         DONE: if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // FSM and EMITTED registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         emitted_q <= '0;
      end else begin
         state_q   <= state_d;
         emitted_q <= emitted_d;
      end
   end

   generic_lfsr #(.N(NBIT_DATA)) u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (lfsr_load),
      .step_i  (lfsr_step),
      .seed_i  (NBIT_DATA'(seed_q)),
      .coeff_i (NBIT_DATA'(coeff_q)),
      .q_o     (lfsr)
   );

   assign pattern_valid_o = (state_q == RUN);
   assign pattern_o       = (state_q == RUN) ? lfsr : '0;
   assign done_o          = (state_q == DONE);

   // Read mux; START/ABORT read as 0, unmapped or non-read cycles return 0
   always_comb begin
      bus.data_sw_o = '0;
      if (rd_en) begin
         case (idx)
            REG_CONTROL: bus.data_sw_o[CTRL_CONT] = cont;
            REG_SEED:    bus.data_sw_o = seed_q;
            REG_COEFF:   bus.data_sw_o = coeff_q;
            REG_COUNT:   bus.data_sw_o = count_q;
            REG_STATUS: begin
               bus.data_sw_o[STAT_BUSY] = busy;
               bus.data_sw_o[STAT_DONE] = (state_q == DONE);
            end
            REG_EMITTED: bus.data_sw_o = emitted_q;
            default: ;
         endcase
      end
   end
endmodule
